cell_mem_sched: RTL and testbench
=================================

CELL_MEM_SCHED -- requirements
Module: cell_mem_sched

Interface
REQ-001 Parameters (name, default, meaning), one per line:
  SCREEN_WIDTH 1024 active pixels per line
  SCREEN_HEIGHT 768 active lines
  H_TOTAL 1344 pixels per line including blanking
  V_TOTAL 806 lines per frame including blanking
  BOARD_W 128 cells per row (8x8-pixel cells)
  BOARD_H 96 cell rows
REQ-002 Ports (name, direction, width, meaning), one per line; one clock; reset is asynchronous and active-low:
  clk_in  in  1  pixel clock
  rst_n_in  in  1  asynchronous active-low reset
  hcount_in  in  11  pixel column, increments once per clk_in, wraps at H_TOTAL-1
  vcount_in  in  10  line, increments at hcount wrap, wraps at V_TOTAL-1
  upd_req_in  in  1  update-engine access request
  upd_we_in  in  1  1 = write, 0 = read
  upd_addr_in  in  14  cell index, row*BOARD_W+col
  upd_wdata_in  in  1  write data
  upd_done_in  in  1  pulse: next generation fully written
  upd_gnt_out  out  1  request accepted this cycle
  upd_rvalid_out  out  1  read data valid
  upd_rdata_out  out  1  read data
  gen_tick_out  out  1  one-cycle pulse on bank swap
  is_alive_out  out  1  cell state for the current pixel, to cell_render
  mem_addr_out  out  15  {bank, cell index} to single-port BRAM
  mem_we_out  out  1  BRAM write enable
  mem_wdata_out  out  1  BRAM write data
  mem_rdata_in  in  1  BRAM read data, 2-cycle latency from address

Function
REQ-003 Two banks: disp_sel selects the display bank; the display and update-engine reads use bank disp_sel; update-engine writes use bank ~disp_sel.
REQ-004 Display slot = cycle where (hcount_in[2:0]==5 and hcount_in < SCREEN_WIDTH-8) or hcount_in == H_TOTAL-3, and the target row is < BOARD_H.
REQ-005 Mid-line slot target = col (hcount_in>>3)+1, row vcount_in>>3; slot at H_TOTAL-3 targets col 0, row ((vcount_in==V_TOTAL-1) ? 0 : vcount_in+1)>>3.
REQ-006 In a display slot: mem_addr_out={disp_sel,row*BOARD_W+col}, mem_we_out=0; the data is sampled 2 cycles later and registered into is_alive_out, so it is valid from the next cell's first pixel.
REQ-007 is_alive_out SHALL be 0 whenever the current pixel is outside the active area.
REQ-008 Display has absolute priority: upd_gnt_out=0 in display slots; the requester holds req/we/addr/wdata stable until granted.
REQ-009 In any other cycle in state RUN with upd_req_in=1: upd_gnt_out=1 combinationally, and the memory port drives the update access that cycle.
REQ-010 A granted read asserts upd_rvalid_out with upd_rdata_out exactly 2 cycles after the grant; a granted write has no response.
REQ-011 State machine RUN/SWAP_PEND: in RUN, upd_done_in=1 moves to SWAP_PEND next cycle; in SWAP_PEND, no grants are issued.
REQ-012 In SWAP_PEND, on a cycle with hcount_in==0 and vcount_in==SCREEN_HEIGHT, disp_sel toggles, gen_tick_out=1 for that cycle, and the state returns to RUN.
REQ-013 upd_done_in in SWAP_PEND is ignored; upd_done_in on the vblank-start cycle itself defers the swap to the next frame's vblank start.
REQ-014 Reads in flight at a swap complete using the bank latched at issue.

Reset
REQ-015 While rst_n_in=0: is_alive_out, upd_gnt_out, upd_rvalid_out, upd_rdata_out, gen_tick_out, mem_we_out=0; mem_addr_out=0; disp_sel=0; state RUN.
REQ-016 Reset mid-operation discards in-flight reads; no rvalid follows the release of reset.

Verification
REQ-017 Bench SHALL cover:
  - Bank0 cell 1 = 1, others = 0; scan line 0 -> is_alive_out=1 exactly for hcount 8..15, 0 elsewhere.
  - upd_req_in held with hcount_in=13 (slot) -> gnt=0 at 13, gnt=1 at 14, mem_addr_out at 14 = upd_addr_in.
  - Read of addr 5 granted at cycle T -> upd_rvalid_out=1 at T+2 only, upd_rdata_out = bank0[5].
  - Write addr 7 = 1, upd_done_in, run to vcount 768/hcount 0 -> gen_tick_out one pulse, disp_sel=1, display then shows cell 7 alive.
  - upd_done_in on the vblank-start cycle -> no swap this frame, swap one frame later; requests during SWAP_PEND never granted.
  - rst_n_in low for 1 cycle one cycle after a read grant -> no rvalid, all outputs at reset values.

Source files
------------

// File: rtl/cell_mem_sched.sv
// Arbitrates one single-port cell BRAM between the raster display and the update engine.
// Two banks are double-buffered and swapped at vblank start once a new generation is done.
module cell_mem_sched #(
   parameter int unsigned SCREEN_WIDTH  = 1024,
   parameter int unsigned SCREEN_HEIGHT = 768,
   parameter int unsigned H_TOTAL       = 1344,
   parameter int unsigned V_TOTAL       = 806,
   parameter int unsigned BOARD_W       = 128,
   parameter int unsigned BOARD_H       = 96
) (
   input  logic        clk_in,
   input  logic        rst_n_in,
   input  logic [10:0] hcount_in,
   input  logic [9:0]  vcount_in,
   input  logic        upd_req_in,
   input  logic        upd_we_in,
   input  logic [13:0] upd_addr_in,
   input  logic        upd_wdata_in,
   input  logic        upd_done_in,
   output logic        upd_gnt_out,
   output logic        upd_rvalid_out,
   output logic        upd_rdata_out,
   output logic        gen_tick_out,
   output logic        is_alive_out,
   output logic [14:0] mem_addr_out,
   output logic        mem_we_out,
   output logic        mem_wdata_out,
   input  logic        mem_rdata_in
);

   localparam int unsigned HW = 11;
   localparam int unsigned VW = 10;
   localparam int unsigned CW = 14;

   typedef enum logic {ST_RUN = 1'b0, ST_SWAP_PEND = 1'b1} state_e;

   state_e state_q, state_d;

   logic          h_last, v_last, nxt_act, vblank_start;
   logic [VW-1:0] v_inc, v_nxt;
   logic          mid_slot, end_slot, disp_slot;
   logic [CW-1:0] mid_cell, end_cell, disp_cell;
   logic          run_c, swap_c, gnt_c;

   logic disp_sel_q, disp_sel_d;
   logic disp_p1_q, disp_p1_d, disp_p2_q, disp_p2_d;
   logic rd_p1_q, rd_p1_d, rd_p2_q, rd_p2_d;
   logic cell_q, cell_d;
   logic is_alive_q, is_alive_d;

   // Raster decode: display slots fetch the next cell one cell-time ahead
   always_comb begin
      h_last       = (hcount_in == HW'(H_TOTAL - 1));
      v_last       = (vcount_in == VW'(V_TOTAL - 1));
      v_inc        = v_last ? '0 : vcount_in + VW'(1);
      v_nxt        = h_last ? v_inc : vcount_in;
      mid_slot     = (hcount_in[2:0] == 3'd5) && (hcount_in < HW'(SCREEN_WIDTH - 8))
                     && ((vcount_in >> 3) < VW'(BOARD_H));
      end_slot     = (hcount_in == HW'(H_TOTAL - 3)) && ((v_inc >> 3) < VW'(BOARD_H));
      mid_cell     = CW'(vcount_in >> 3) * CW'(BOARD_W) + CW'(hcount_in >> 3) + CW'(1);
      end_cell     = CW'(v_inc >> 3) * CW'(BOARD_W);
      disp_slot    = rst_n_in && (mid_slot || end_slot);
      disp_cell    = end_slot ? end_cell : mid_cell;
      nxt_act      = (h_last || (hcount_in < HW'(SCREEN_WIDTH - 1)))
                     && (v_nxt < VW'(SCREEN_HEIGHT));
      vblank_start = (hcount_in == '0) && (vcount_in == VW'(SCREEN_HEIGHT));
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) state_q <= ST_RUN;
      else           state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_RUN:       if (upd_done_in)  state_d = ST_SWAP_PEND;
         ST_SWAP_PEND: if (vblank_start) state_d = ST_RUN;
         default:      state_d = ST_RUN;
      endcase
   end

   always_comb begin
      run_c  = (state_q == ST_RUN);
      swap_c = (state_q == ST_SWAP_PEND) && vblank_start;
   end

   // Memory port: display slot wins, otherwise a granted update access
   always_comb begin
      gnt_c         = rst_n_in && run_c && upd_req_in && !disp_slot;
      mem_addr_out  = '0;
      mem_we_out    = 1'b0;
      mem_wdata_out = 1'b0;
      if (disp_slot) begin
         mem_addr_out = {disp_sel_q, disp_cell};
      end else if (gnt_c) begin
         mem_addr_out  = {disp_sel_q ^ upd_we_in, upd_addr_in};
         mem_we_out    = upd_we_in;
         mem_wdata_out = upd_we_in & upd_wdata_in;
      end
   end

   always_comb begin
      disp_sel_d = disp_sel_q ^ swap_c;
      disp_p1_d  = disp_slot;
      disp_p2_d  = disp_p1_q;
      rd_p1_d    = gnt_c && !upd_we_in;
      rd_p2_d    = rd_p1_q;
      cell_d     = disp_p2_q ? mem_rdata_in : cell_q;
      is_alive_d = nxt_act && cell_d;
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         disp_sel_q <= 1'b0;
         disp_p1_q  <= 1'b0;
         disp_p2_q  <= 1'b0;
         rd_p1_q    <= 1'b0;
         rd_p2_q    <= 1'b0;
         cell_q     <= 1'b0;
         is_alive_q <= 1'b0;
      end else begin
         disp_sel_q <= disp_sel_d;
         disp_p1_q  <= disp_p1_d;
         disp_p2_q  <= disp_p2_d;
         rd_p1_q    <= rd_p1_d;
         rd_p2_q    <= rd_p2_d;
         cell_q     <= cell_d;
         is_alive_q <= is_alive_d;
      end
   end

   // Read data comes straight from the BRAM in the cycle its latency completes
   assign upd_gnt_out    = gnt_c;
   assign upd_rvalid_out = rd_p2_q;
   assign upd_rdata_out  = rd_p2_q & mem_rdata_in;
   assign gen_tick_out   = swap_c;
   assign is_alive_out   = is_alive_q;

endmodule

// File: tb/tb_cell_mem_sched.sv
// Directed bench for cell_mem_sched with a 2-cycle-latency BRAM model and a read-response scoreboard.
module tb_cell_mem_sched;

   logic        clk_in = 1'b0;
   logic        rst_n_in;
   logic [10:0] hcount_in;
   logic [9:0]  vcount_in;
   logic        upd_req_in, upd_we_in, upd_wdata_in, upd_done_in;
   logic [13:0] upd_addr_in;
   logic        upd_gnt_out, upd_rvalid_out, upd_rdata_out, gen_tick_out, is_alive_out;
   logic [14:0] mem_addr_out;
   logic        mem_we_out, mem_wdata_out, mem_rdata_in;

   int n_chk  = 0;
   int n_fail = 0;
   int cyc    = 0;

   typedef struct { int cyc; logic data; } exp_t;
   exp_t sb_q[$];
   exp_t e;

   bit mem [0:32767];
   bit rd1, rd2;
   bit bd_we = 1'b0;
   int bd_addr = 0;
   bit bd_data = 1'b0;

   always #5 clk_in = ~clk_in;
   always @(posedge clk_in) cyc <= cyc + 1;

   cell_mem_sched dut (
      .clk_in(clk_in), .rst_n_in(rst_n_in), .hcount_in(hcount_in), .vcount_in(vcount_in),
      .upd_req_in(upd_req_in), .upd_we_in(upd_we_in), .upd_addr_in(upd_addr_in),
      .upd_wdata_in(upd_wdata_in), .upd_done_in(upd_done_in), .upd_gnt_out(upd_gnt_out),
      .upd_rvalid_out(upd_rvalid_out), .upd_rdata_out(upd_rdata_out),
      .gen_tick_out(gen_tick_out), .is_alive_out(is_alive_out), .mem_addr_out(mem_addr_out),
      .mem_we_out(mem_we_out), .mem_wdata_out(mem_wdata_out), .mem_rdata_in(mem_rdata_in)
   );

   // Single-port BRAM, read data two cycles after the address; bank0 cell 1 preloaded in reset
   always @(posedge clk_in) begin
      if (!rst_n_in)       mem[1] <= 1'b1;
      else if (bd_we)      mem[bd_addr] <= bd_data;
      else if (mem_we_out) mem[mem_addr_out] <= mem_wdata_out;
      rd1 <= mem[mem_addr_out];
      rd2 <= rd1;
   end
   assign mem_rdata_in = rd2;

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (h=%0d v=%0d cyc=%0d)",
                  name, act, exp, hcount_in, vcount_in, cyc);
      end
   endtask

   // Read-response monitor
   always @(negedge clk_in) begin
      if (sb_q.size() != 0 && sb_q[0].cyc < cyc) begin
         n_chk++;
         n_fail++;
         $display("FAIL rvalid_missing: no rvalid seen, expected at cycle %0d", sb_q[0].cyc);
         e = sb_q.pop_front();
      end
      if (upd_rvalid_out === 1'b1) begin
         if (sb_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL rvalid_unexpected: rvalid=1 at cycle %0d, expected none", cyc);
         end else begin
            e = sb_q.pop_front();
            chk("rvalid_cycle", cyc, e.cyc);
            chk("rdata", int'(upd_rdata_out), int'(e.data));
         end
      end
   end

   task automatic step_to(input int h, input int v);
      @(posedge clk_in);
      #1;
      hcount_in = 11'(h);
      vcount_in = 10'(v);
   endtask

   task automatic adv();
      int h;
      int v;
      h = int'(hcount_in);
      v = int'(vcount_in);
      if (h == 1343) begin
         h = 0;
         v = (v == 805) ? 0 : v + 1;
      end else begin
         h = h + 1;
      end
      step_to(h, v);
   endtask

   // Granted update access in a non-slot cycle; reads push their expected response
   task automatic access(input logic we, input int addr, input logic wd,
                         input int exp_maddr, input logic exp_rd);
      upd_req_in   = 1'b1;
      upd_we_in    = we;
      upd_addr_in  = 14'(addr);
      upd_wdata_in = wd;
      @(negedge clk_in);
      chk("gnt", int'(upd_gnt_out), 1);
      chk("mem_addr_upd", int'(mem_addr_out), exp_maddr);
      chk("mem_we", int'(mem_we_out), int'(we));
      if (we) chk("mem_wdata", int'(mem_wdata_out), int'(wd));
      else    sb_q.push_back('{cyc + 2, exp_rd});
      adv();
      upd_req_in   = 1'b0;
      upd_we_in    = 1'b0;
      upd_wdata_in = 1'b0;
   endtask

   task automatic scan_line(input int lo, input int hi);
      step_to(1336, 805);
      do begin
         adv();
         @(negedge clk_in);
         if (vcount_in == 10'd0)
            chk("is_alive", int'(is_alive_out), (hcount_in >= lo && hcount_in <= hi) ? 1 : 0);
      end while (!(vcount_in == 10'd0 && hcount_in == 11'd1343));
   endtask

   task automatic chk_reset_outputs();
      chk("rst_is_alive", int'(is_alive_out), 0);
      chk("rst_gnt", int'(upd_gnt_out), 0);
      chk("rst_rvalid", int'(upd_rvalid_out), 0);
      chk("rst_rdata", int'(upd_rdata_out), 0);
      chk("rst_gen_tick", int'(gen_tick_out), 0);
      chk("rst_mem_we", int'(mem_we_out), 0);
      chk("rst_mem_addr", int'(mem_addr_out), 0);
      chk("rst_mem_wdata", int'(mem_wdata_out), 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n_in     = 1'b0;
      hcount_in    = 11'd5;
      vcount_in    = 10'd0;
      upd_req_in   = 1'b1;
      upd_we_in    = 1'b1;
      upd_addr_in  = 14'd3;
      upd_wdata_in = 1'b1;
      upd_done_in  = 1'b0;
      repeat (3) @(posedge clk_in);
      @(negedge clk_in);
      chk_reset_outputs();
      upd_req_in   = 1'b0;
      upd_we_in    = 1'b0;
      upd_wdata_in = 1'b0;
      step_to(1336, 805);
      rst_n_in = 1'b1;

      // Bank0 holds only cell 1: line 0 lights pixels 8..15
      scan_line(8, 15);

      // Slot blocks the held request, next cycle grants; then back-to-back reads
      bd_addr = 5;
      bd_data = 1'b1;
      bd_we   = 1'b1;
      step_to(12, 0);
      bd_we = 1'b0;
      adv();
      upd_req_in  = 1'b1;
      upd_we_in   = 1'b0;
      upd_addr_in = 14'd5;
      @(negedge clk_in);
      chk("gnt_in_slot", int'(upd_gnt_out), 0);
      chk("mem_addr_disp", int'(mem_addr_out), 2);
      chk("mem_we_disp", int'(mem_we_out), 0);
      adv();
      access(1'b0, 5, 1'b0, 5, 1'b1);
      adv();
      adv();
      access(1'b0, 1, 1'b0, 1, 1'b1);
      access(1'b0, 2, 1'b0, 2, 1'b0);
      repeat (6) begin
         adv();
         @(negedge clk_in);
      end

      // Write cell 7 into the back bank, finish the generation, swap at vblank start
      step_to(100, 0);
      access(1'b1, 7, 1'b1, 16384 + 7, 1'b0);
      step_to(200, 0);
      upd_done_in = 1'b1;
      @(negedge clk_in);
      chk("gen_tick_idle", int'(gen_tick_out), 0);
      adv();
      upd_done_in = 1'b0;
      upd_req_in  = 1'b1;
      upd_we_in   = 1'b0;
      upd_addr_in = 14'd1;
      @(negedge clk_in);
      chk("gnt_pend", int'(upd_gnt_out), 0);
      repeat (3) begin
         adv();
         @(negedge clk_in);
         chk("gnt_pend", int'(upd_gnt_out), 0);
      end
      step_to(1343, 767);
      @(negedge clk_in);
      chk("gnt_pend", int'(upd_gnt_out), 0);
      chk("gen_tick_pre", int'(gen_tick_out), 0);
      adv();
      @(negedge clk_in);
      chk("gen_tick_swap", int'(gen_tick_out), 1);
      chk("gnt_swap_cycle", int'(upd_gnt_out), 0);
      adv();
      access(1'b0, 1, 1'b0, 16384 + 1, 1'b0);
      @(negedge clk_in);
      chk("gen_tick_once", int'(gen_tick_out), 0);
      repeat (3) begin
         adv();
         @(negedge clk_in);
      end
      scan_line(56, 63);
      step_to(5, 0);
      @(negedge clk_in);
      chk("disp_bank1", int'(mem_addr_out), 16384 + 1);
      adv();
      access(1'b0, 7, 1'b0, 16384 + 7, 1'b1);

      // Done on the vblank-start cycle defers the swap a whole frame
      step_to(0, 768);
      upd_done_in = 1'b1;
      @(negedge clk_in);
      chk("gen_tick_deferred", int'(gen_tick_out), 0);
      adv();
      upd_done_in = 1'b0;
      upd_req_in  = 1'b1;
      upd_we_in   = 1'b0;
      upd_addr_in = 14'd1;
      @(negedge clk_in);
      chk("gnt_pend2", int'(upd_gnt_out), 0);
      adv();
      upd_done_in = 1'b1;
      @(negedge clk_in);
      chk("gnt_pend2", int'(upd_gnt_out), 0);
      adv();
      upd_done_in = 1'b0;
      @(negedge clk_in);
      chk("gnt_pend2", int'(upd_gnt_out), 0);
      step_to(5, 0);
      @(negedge clk_in);
      chk("disp_still_bank1", int'(mem_addr_out), 16384 + 1);
      adv();
      @(negedge clk_in);
      chk("gnt_pend2", int'(upd_gnt_out), 0);
      step_to(1343, 767);
      @(negedge clk_in);
      chk("gen_tick_pre2", int'(gen_tick_out), 0);
      chk("gnt_pend2", int'(upd_gnt_out), 0);
      adv();
      @(negedge clk_in);
      chk("gen_tick_swap2", int'(gen_tick_out), 1);
      chk("gnt_swap_cycle2", int'(upd_gnt_out), 0);
      adv();
      access(1'b0, 1, 1'b0, 1, 1'b1);
      @(negedge clk_in);
      chk("gen_tick_once2", int'(gen_tick_out), 0);
      step_to(5, 0);
      @(negedge clk_in);
      chk("disp_bank0", int'(mem_addr_out), 1);

      // Reset one cycle after a read grant discards the read
      step_to(2, 0);
      upd_req_in  = 1'b1;
      upd_we_in   = 1'b0;
      upd_addr_in = 14'd1;
      @(negedge clk_in);
      chk("gnt_before_rst", int'(upd_gnt_out), 1);
      adv();
      rst_n_in = 1'b0;
      @(negedge clk_in);
      chk_reset_outputs();
      adv();
      rst_n_in   = 1'b1;
      upd_req_in = 1'b0;
      repeat (5) begin
         adv();
         @(negedge clk_in);
         chk("rvalid_after_rst", int'(upd_rvalid_out), 0);
      end
      step_to(5, 0);
      @(negedge clk_in);
      chk("disp_bank_after_rst", int'(mem_addr_out), 1);

      repeat (4) begin
         adv();
         @(negedge clk_in);
      end
      chk("scoreboard_empty", sb_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
